// File: rtl/load_store_unit.sv
// load_store_unit: byte/word load-store initiator for the single-port data RAM.
// Ports: req_* handshake in, rsp_* pulse out, ram_* to a registered-read RAM.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] ram_a,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        ram_rw
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FAULT,
    S_RD_WAIT,
    S_RD_DATA,
    S_WR_WAIT,
    S_RMW_WAIT,
    S_RMW_READ,
    S_RMW_WRITE
  } state_e;

  state_e      state_q, state_d;

  logic        size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  wbyte_q, wbyte_d;

  logic [31:0] ram_a_q, ram_a_d;
  logic [31:0] ram_din_q, ram_din_d;
  logic        ram_rw_q, ram_rw_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        fault_w;
  logic [7:0]  rd_byte;
  logic [31:0] byte_ext;
  logic [31:0] merged;

  assign req_ready = (state_q == S_IDLE) && !rst;

  assign fault_w = (req_size && (req_addr[1:0] != 2'b00)) ||
                   ({2'b00, req_addr[31:2]} >= MEM_WORDS);

  // little-endian lane pick and lane replace
  always_comb begin
    rd_byte = ram_dout[7:0];
    merged  = ram_dout;
    unique case (lane_q)
      2'd0: begin
        rd_byte      = ram_dout[7:0];
        merged[7:0]  = wbyte_q;
      end
      2'd1: begin
        rd_byte      = ram_dout[15:8];
        merged[15:8] = wbyte_q;
      end
      2'd2: begin
        rd_byte       = ram_dout[23:16];
        merged[23:16] = wbyte_q;
      end
      default: begin
        rd_byte       = ram_dout[31:24];
        merged[31:24] = wbyte_q;
      end
    endcase
  end

  assign byte_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (fault_w)         state_d = S_FAULT;
          else if (!req_write) state_d = S_RD_WAIT;
          else if (req_size)   state_d = S_WR_WAIT;
          else                 state_d = S_RMW_WAIT;
        end
      end
      S_FAULT:     state_d = S_IDLE;
      S_RD_WAIT:   state_d = S_RD_DATA;
      S_RD_DATA:   state_d = S_IDLE;
      S_WR_WAIT:   state_d = S_IDLE;
      S_RMW_WAIT:  state_d = S_RMW_READ;
      S_RMW_READ:  state_d = S_RMW_WRITE;
      S_RMW_WRITE: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // output / datapath next values; strobes default low
  always_comb begin
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    wbyte_d     = wbyte_q;
    ram_a_d     = ram_a_q;
    ram_din_d   = ram_din_q;
    ram_rw_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_rdata_d = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !fault_w) begin
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
          wbyte_d  = req_wdata[7:0];
          ram_a_d  = {2'b00, req_addr[31:2]};
          if (req_write && req_size) begin
            ram_din_d = req_wdata;
            ram_rw_d  = 1'b1;
          end
        end
      end
      S_FAULT: begin
        rsp_valid_d = 1'b1;
        rsp_fault_d = 1'b1;
      end
      S_RD_DATA: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = size_q ? ram_dout : byte_ext;
      end
      S_WR_WAIT: rsp_valid_d = 1'b1;
      S_RMW_READ: begin
        ram_din_d = merged;
        ram_rw_d  = 1'b1;
      end
      S_RMW_WRITE: rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q      <= 1'b0;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      wbyte_q     <= 8'h0;
      ram_a_q     <= 32'h0;
      ram_din_q   <= 32'h0;
      ram_rw_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      wbyte_q     <= wbyte_d;
      ram_a_q     <= ram_a_d;
      ram_din_q   <= ram_din_d;
      ram_rw_q    <= ram_rw_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_din   = ram_din_q;
  assign ram_rw    = ram_rw_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + random bench with a transaction-level model.
// Bench owns the data RAM and a reference copy of memory.
module tb_load_store_unit;
  localparam int MW = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_size = 1'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] ram_a;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_rw;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .ram_a(ram_a), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_rw(ram_rw)
  );

  // the RAM: registered read, no reset
  logic [31:0] mem [MW];
  always @(posedge clk) begin
    if (ram_rw && ram_a < MW) mem[ram_a[12:0]] <= ram_din;
    ram_dout <= (ram_a < MW) ? mem[ram_a[12:0]] : 32'h0;
  end

  // transaction-level model state
  logic [31:0] model_mem [MW];
  int          n = 0;
  int          free_after = 0;
  int          pend_edge = 0;
  bit          pend = 0, pend_wr = 0, pend_fault = 0;
  logic [31:0] pend_data = 0, pend_wdata = 0, pend_idx = 0;
  bit          out_valid = 0, out_fault = 0, rw_exp = 0;
  bit          reset_seen = 0, acc = 0;
  logic [31:0] out_data = 0;
  logic [32:0] rlog [$];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
    else
      pass_cnt++;
  endtask

  // model of one clock edge, from the request/response rules
  task automatic model_step();
    logic [31:0] w, idx;
    int lo, lat;
    bit flt;
    out_valid = 0; reset_seen = 0; acc = 0;
    if (pend && n == pend_edge && pend_wr && !pend_fault)
      model_mem[pend_idx[12:0]] = pend_wdata;
    if (rst) begin
      pend = 0; free_after = n; reset_seen = 1;
    end else begin
      if (pend && n == pend_edge) begin
        out_valid = 1; out_data = pend_data; out_fault = pend_fault;
        pend = 0;
      end
      if (req_valid && (n - 1) >= free_after) begin
        acc = 1;
        idx = {2'b00, req_addr[31:2]};
        lo  = int'(req_addr[1:0]);
        flt = (req_size && lo != 0) || (idx >= MW);
        pend = 1; pend_idx = idx; pend_wr = req_write; pend_fault = flt;
        pend_data = 0; pend_wdata = 0;
        if (flt) lat = 1;
        else begin
          w = model_mem[idx[12:0]];
          if (!req_write) begin
            lat = 2;
            if (req_size) pend_data = w;
            else begin
              pend_data = (w >> (8 * lo)) & 32'hFF;
              if (req_signed && pend_data[7]) pend_data = pend_data | 32'hFFFF_FF00;
            end
          end else if (req_size) begin
            lat = 1; pend_wdata = req_wdata;
          end else begin
            lat = 3;
            pend_wdata = (w & ~(32'hFF << (8 * lo))) |
                         ({24'h0, req_wdata[7:0]} << (8 * lo));
          end
        end
        pend_edge = n + lat; free_after = n + lat;
      end
    end
    rw_exp = pend && pend_wr && !pend_fault && (n == pend_edge - 1);
  endtask

  // compare process: DUT outputs vs model after every edge
  always @(negedge clk) begin
    if (n > 0) begin
      chk("req_ready", 32'(req_ready), 32'((n >= free_after) && !rst));
      chk("rsp_valid", 32'(rsp_valid), 32'(out_valid));
      if (out_valid) begin
        chk("rsp_rdata", rsp_rdata, out_data);
        chk("rsp_fault", 32'(rsp_fault), 32'(out_fault));
      end
      if (rsp_valid) rlog.push_back({rsp_fault, rsp_rdata});
      chk("ram_rw", 32'(ram_rw), 32'(rw_exp));
      if (rw_exp) chk("ram_din", ram_din, pend_wdata);
      if (pend && !pend_fault) chk("ram_a", ram_a, pend_idx);
      if (reset_seen) begin
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_din", ram_din, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_fault", 32'(rsp_fault), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    n++;
    model_step();
    #1;
  endtask

  task automatic send(bit w, bit s, bit sg, logic [31:0] a,
                      logic [31:0] d, bit rst_e1);
    int k;
    req_valid = 1; req_write = w; req_size = s;
    req_signed = sg; req_addr = a; req_wdata = d;
    k = 0;
    do begin
      tick();
      k++;
    end while (!acc && k < 20);
    if (!acc) chk("accept_timeout", 32'(acc), 32'h1);
    req_valid = 0;
    req_addr = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    if (rst_e1) begin
      rst = 1;
      tick();
      rst = 0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (pend && k < 20) begin
      tick();
      k++;
    end
    if (pend) chk("drain_timeout", 32'(pend), 32'h0);
  endtask

  logic [31:0] lit_d [9] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDE5ABEEF,
                             32'hFFFFFFDE, 32'h000000DE, 32'hFFFFFFEF,
                             32'h0, 32'h0};
  bit lit_f [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

  initial begin
    int r, bad;
    logic [32:0] e;
    for (int i = 0; i < MW; i++) begin
      r = int'($urandom);
      mem[i] <= 32'(r);
      model_mem[i] = 32'(r);
    end
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();

    // word store/load, byte store merge, byte loads, faults
    send(1, 1, 0, 32'h10, 32'hDEADBEEF, 0);
    send(0, 1, 0, 32'h10, 32'h0, 0);
    send(1, 0, 0, 32'h12, 32'h0000005A, 0);
    send(0, 1, 0, 32'h10, 32'h0, 0);
    send(0, 0, 1, 32'h13, 32'h0, 0);
    send(0, 0, 0, 32'h13, 32'h0, 0);
    send(0, 0, 1, 32'h10, 32'h0, 0);
    send(0, 1, 0, 32'h11, 32'h0, 0);
    send(1, 1, 0, 32'h8000, 32'h12345678, 0);
    drain();
    tick();
    chk("dir_rsp_count", 32'(rlog.size()), 32'd9);
    if (rlog.size() >= 9) begin
      for (int i = 0; i < 9; i++) begin
        e = rlog[i];
        chk("dir_rdata", e[31:0], lit_d[i]);
        chk("dir_fault", 32'(e[32]), 32'(lit_f[i]));
      end
    end
    chk("model_word4", model_mem[4], 32'hDE5ABEEF);

    // byte store cut by reset at E1
    send(1, 0, 0, 32'h12, 32'h00000077, 1);
    repeat (4) tick();
    chk("rst_no_rsp", 32'(rlog.size()), 32'd9);
    chk("rst_mem_word4", mem[4], 32'hDE5ABEEF);
    chk("rst_model_word4", model_mem[4], 32'hDE5ABEEF);

    // random back-to-back traffic with rare resets
    for (int c = 0; c < 3000; c++) begin
      req_valid  = ($urandom_range(0, 9) < 8);
      req_write  = 1'($urandom_range(0, 1));
      req_size   = 1'($urandom_range(0, 1));
      req_signed = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 15));
      if (r == 0) req_addr = $urandom | 32'h0000_8000;
      else req_addr = {26'h0, 4'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3))};
      req_wdata = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0;
    req_valid = 0;
    drain();
    tick();
    tick();

    bad = 0;
    for (int i = 0; i < MW; i++)
      if (mem[i] !== model_mem[i]) bad++;
    chk("mem_final", 32'(bad), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access initiator that drives the single-port, word-addressed data RAM (registered read, one-cycle latency) on behalf of the execute stage.
- Accepts byte-addressed load/store requests through a valid/ready handshake.
- Performs word and byte accesses, byte stores by read-modify-write.
- Returns a single-cycle response pulse with read data or a fault flag.
- Sits between the control unit and random_access_memory, and is the only block that asserts the RAM write strobe.

Parameters:
MEM_WORDS, 8192, RAM depth in 32-bit words; word index >= MEM_WORDS faults.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  LSU can accept; combinational, high only in IDLE and only while rst low
req_write  input  1  1 store, 0 load
req_size  input  1  1 word, 0 byte
req_signed  input  1  byte load sign-extends when 1; ignored otherwise
req_addr  input  32  byte address
req_wdata  input  32  store data; byte stores use bits 7:0
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load result; 0 for stores and faults
rsp_fault  output  1  request rejected, no RAM write performed
ram_a  output  32  RAM word index (req_addr[31:2], zero-extended)
ram_din  output  32  RAM write data
ram_dout  input  32  RAM read data, valid the edge after RAM samples ram_a
ram_rw  output  1  RAM write strobe (1 write, 0 read)

Behaviour:
- Reset: state IDLE; ram_a, ram_din, rsp_rdata = 0; ram_rw, rsp_valid, rsp_fault = 0. All outputs are registered except req_ready.
- Accept at edge E0 when req_valid && req_ready. Request fields are captured into internal registers, so inputs may change after E0.
- Fault check at accept: fault if (req_size=1 && req_addr[1:0]!=0) or req_addr[31:2] >= MEM_WORDS.
  - E0: state FAULT; ram_a and ram_rw unchanged.
  - E1: rsp_valid=1, rsp_fault=1, rsp_rdata=0; state IDLE.
- Word load:
  - E0: ram_a set, ram_rw=0; state RD_WAIT.
  - E1: RAM reads; state RD_DATA.
  - E2: rsp_rdata=ram_dout, rsp_valid=1; state IDLE.
- Byte load: same timing as word load.
  - Lane is little-endian: addr[1:0]=0 selects bits 7:0, 3 selects bits 31:24.
  - Result is zero-extended, or sign-extended from bit 7 when req_signed=1.
- Word store:
  - E0: ram_a set, ram_din=req_wdata, ram_rw=1; state WR_WAIT.
  - E1: RAM writes; ram_rw=0, rsp_valid=1, rsp_rdata=0; state IDLE.
- Byte store (read-modify-write):
  - E0: ram_a set, ram_rw=0; state RMW_WAIT.
  - E1: state RMW_READ.
  - E2: ram_din = ram_dout with the selected lane replaced by wdata[7:0]; ram_rw=1; state RMW_WRITE.
  - E3: RAM writes; ram_rw=0, rsp_valid=1; state IDLE.
- ram_rw is high for exactly one cycle per store and never during loads or faults.
- rsp_valid is always a single-cycle pulse. There is no response backpressure; the consumer must take the response in that cycle.
- Next accept is possible at the edge following the response edge: a load occupies 3 cycles of throughput, a word store 2, a byte store 4, a fault 2.
- req_valid while not ready is ignored, not queued.
- Reset mid-operation:
  - Any state returns to IDLE; pending response is dropped; ram_rw cleared.
  - Reset in RMW_WAIT or RMW_READ: no write occurs.
  - Reset at the same edge the RAM samples ram_rw=1 cannot cancel that write, because the RAM has no reset.

Test Plan:
1. Word store 0xDEADBEEF to 0x10 -> ram_a=4, ram_din=0xDEADBEEF, ram_rw high exactly one cycle, rsp_valid at E1 with rdata 0, fault 0. Then word load 0x10 -> rsp_rdata=0xDEADBEEF at E2.
2. From scenario 1, byte store 0x5A to 0x12 -> ram_rw low at E0/E1, high in cycle after E2 with ram_din=0xDE5ABEEF, rsp_valid at E3. Word load 0x10 -> 0xDE5ABEEF.
3. Byte loads of 0x13 on word 0xDE5ABEEF -> req_signed=1 gives 0xFFFFFFDE; req_signed=0 gives 0x000000DE; byte 0x10 signed gives 0xFFFFFFEF.
4. Word load 0x11 and word store 0x8000 (MEM_WORDS=8192) -> rsp_valid with rsp_fault=1, rdata 0 at E1; ram_rw never asserted; memory unchanged.
5. Byte store to 0x12, rst asserted at E1 for one cycle -> ram_rw stays 0, no rsp_valid, word at 0x10 unchanged, req_ready high the cycle after rst deasserts.
6. req_valid held high continuously with alternating loads/stores -> req_ready low throughout each operation; accepts occur only in IDLE at the stated spacing; no request lost or duplicated.
